// File: rtl/shiftreg_radix.sv
`default_nettype none
// ============================================================================
//  Module   : shiftreg_radix
//  Purpose  : Partial-result shift register for the RSA Montgomery datapath.
//             Each accepted step captures the adder output rjo, shifts it
//             right by SHIFT bits (radix-2^SHIFT) and fills the top with cin.
//             A step counter tracks ITERS steps and reports busy/done to the
//             controlling FSM. The bits dropped by each step are exposed.
//  Ports    : clk      - rising-edge clock
//             rstb     - asynchronous active-low reset
//             ena      - global enable, low freezes every register
//             clear    - synchronous clear (highest priority)
//             load     - start/restart operation, reg_rji <= ld_data
//             ld_data  - initial register value
//             shift    - step strobe, honoured only while running
//             rjo      - next partial result from the adder
//             cin      - fill bits for the top SHIFT bits
//             reg_rji  - shifted partial result
//             lsb_out  - bits dropped by the last step
//             step_cnt - steps completed in the current operation
//             busy     - operation in progress
//             done     - high while the operation has just completed
//             sticky   - OR of all dropped bits since load/clear
//  Config   : SHREG_STICKY_EN - when defined, sticky is a real flop;
//             otherwise sticky is tied low.
//  Revision : 1.0 - initial release
// ============================================================================
module shiftreg_radix #(
    parameter  int WIDTH = 32,
    parameter  int SHIFT = 1,
    parameter  int ITERS = 32,
    localparam int CNT_W = $clog2(ITERS + 1)
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             ena,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] ld_data,
    input  logic             shift,
    input  logic [WIDTH-1:0] rjo,
    input  logic [SHIFT-1:0] cin,
    output logic [WIDTH-1:0] reg_rji,
    output logic [SHIFT-1:0] lsb_out,
    output logic [CNT_W-1:0] step_cnt,
    output logic             busy,
    output logic             done,
    output logic             sticky
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic   step_ok;    // shift accepted this cycle (enabled, running, no override)
    logic   last_step;  // the accepted shift is the ITERS-th one

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        step_ok    = 1'b0;
        last_step  = 1'b0;
        if (ena) begin
            if (clear) begin
                state_next = IDLE;
            end else if (load) begin
                state_next = RUN;
            end else begin
                case (state)
                    RUN: begin
                        if (shift) begin
                            step_ok   = 1'b1;
                            last_step = (step_cnt == CNT_W'(ITERS - 1));
                            if (last_step) begin
                                state_next = DONE;
                            end
                        end
                    end
                    // DONE lasts exactly one enabled cycle
                    DONE:    state_next = IDLE;
                    default: state_next = state;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // busy/done decode straight from the state flop, so no input reaches them
    assign busy = (state == RUN);
    assign done = (state == DONE);

    // ------------------------------------------------------------------
    // Datapath: shift register, dropped bits, step counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            reg_rji  <= '0;
            lsb_out  <= '0;
            step_cnt <= '0;
        end else if (ena) begin
            if (clear) begin
                reg_rji  <= '0;
                lsb_out  <= '0;
                step_cnt <= '0;
            end else if (load) begin
                reg_rji  <= ld_data;
                lsb_out  <= '0;
                step_cnt <= '0;
            end else if (step_ok) begin
                reg_rji  <= {cin, rjo[WIDTH-1:SHIFT]};
                lsb_out  <= rjo[SHIFT-1:0];
                // Counter stops at ITERS because shifts are ignored outside RUN
                step_cnt <= step_cnt + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Optional sticky bit over all dropped bits
    // ------------------------------------------------------------------
`ifdef SHREG_STICKY_EN
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            sticky <= 1'b0;
        end else if (ena) begin
            if (clear || load) begin
                sticky <= 1'b0;
            end else if (step_ok) begin
                sticky <= sticky | (|rjo[SHIFT-1:0]);
            end
        end
    end
`else
    assign sticky = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_shiftreg_radix.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shiftreg_radix
//  Purpose  : Directed self-checking bench for shiftreg_radix. Instance dut
//             runs WIDTH=8, SHIFT=1, ITERS=8; instance dut2 runs WIDTH=8,
//             SHIFT=2, ITERS=4 for the sticky bit, cin fill and done hold.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_shiftreg_radix;

    localparam int W = 8;

`ifdef SHREG_STICKY_EN
    localparam logic [31:0] STK = 32'd1;
`else
    localparam logic [31:0] STK = 32'd0;
`endif

    logic         clk = 1'b0;
    logic         rstb;
    logic         ena;

    // dut (SHIFT=1, ITERS=8)
    logic         clear, load, shift;
    logic [W-1:0] ld_data, rjo;
    logic [0:0]   cin;
    logic [W-1:0] reg_rji;
    logic [0:0]   lsb_out;
    logic [3:0]   step_cnt;
    logic         busy, done, sticky;

    // dut2 (SHIFT=2, ITERS=4)
    logic         clear2, load2, shift2;
    logic [W-1:0] ld_data2, rjo2;
    logic [1:0]   cin2;
    logic [W-1:0] reg_rji2;
    logic [1:0]   lsb_out2;
    logic [2:0]   step_cnt2;
    logic         busy2, done2, sticky2;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    shiftreg_radix #(.WIDTH(W), .SHIFT(1), .ITERS(8)) dut (
        .clk(clk), .rstb(rstb), .ena(ena), .clear(clear), .load(load),
        .ld_data(ld_data), .shift(shift), .rjo(rjo), .cin(cin),
        .reg_rji(reg_rji), .lsb_out(lsb_out), .step_cnt(step_cnt),
        .busy(busy), .done(done), .sticky(sticky)
    );

    shiftreg_radix #(.WIDTH(W), .SHIFT(2), .ITERS(4)) dut2 (
        .clk(clk), .rstb(rstb), .ena(ena), .clear(clear2), .load(load2),
        .ld_data(ld_data2), .shift(shift2), .rjo(rjo2), .cin(cin2),
        .reg_rji(reg_rji2), .lsb_out(lsb_out2), .step_cnt(step_cnt2),
        .busy(busy2), .done(done2), .sticky(sticky2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // advance one clock and sample 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full-run reference: register values and dropped bits for ld_data=0xA5
    logic [7:0] run_reg [0:8] = '{8'hA5, 8'h52, 8'h29, 8'h14, 8'h0A,
                                  8'h05, 8'h02, 8'h01, 8'h00};
    logic       run_lsb [0:7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        rstb = 1'b0; ena = 1'b0;
        clear = 1'b0; load = 1'b0; shift = 1'b0; ld_data = '0; rjo = '0; cin = '0;
        clear2 = 1'b0; load2 = 1'b0; shift2 = 1'b0; ld_data2 = '0; rjo2 = '0; cin2 = '0;

        // ---------------- reset ----------------
        tick(); tick();
        check("rst_reg",    32'(reg_rji),  32'h0);
        check("rst_lsb",    32'(lsb_out),  32'h0);
        check("rst_cnt",    32'(step_cnt), 32'h0);
        check("rst_busy",   32'(busy),     32'h0);
        check("rst_done",   32'(done),     32'h0);
        check("rst_sticky", 32'(sticky),   32'h0);
        rstb = 1'b1;
        ena  = 1'b1;

        // ---------------- full run ----------------
        load = 1'b1; ld_data = 8'hA5;
        tick();
        load = 1'b0;
        check("run_load_reg",  32'(reg_rji),  32'hA5);
        check("run_load_busy", 32'(busy),     32'h1);
        check("run_load_cnt",  32'(step_cnt), 32'h0);
        for (int i = 0; i < 8; i++) begin
            shift = 1'b1; rjo = run_reg[i]; cin = 1'b0;
            tick();
            check($sformatf("run_reg%0d", i), 32'(reg_rji),  32'(run_reg[i+1]));
            check($sformatf("run_lsb%0d", i), 32'(lsb_out),  32'(run_lsb[i]));
            check($sformatf("run_cnt%0d", i), 32'(step_cnt), 32'(i + 1));
            if (i < 7) begin
                check($sformatf("run_busy%0d", i), 32'(busy), 32'h1);
                check($sformatf("run_done%0d", i), 32'(done), 32'h0);
            end
        end
        shift = 1'b0;
        check("run_done_hi",   32'(done), 32'h1);
        check("run_busy_lo",   32'(busy), 32'h0);
        tick();
        check("run_done_pulse", 32'(done),     32'h0);
        check("run_idle_busy",  32'(busy),     32'h0);
        check("run_cnt_sat",    32'(step_cnt), 32'h8);

        // ---------------- shift ignored in IDLE ----------------
        shift = 1'b1; rjo = 8'hFF; cin = 1'b1;
        tick();
        shift = 1'b0;
        check("idle_reg",  32'(reg_rji),  32'h00);
        check("idle_lsb",  32'(lsb_out),  32'h1);
        check("idle_cnt",  32'(step_cnt), 32'h8);
        check("idle_busy", 32'(busy),     32'h0);

        // ---------------- priority clear > load > shift ----------------
        load = 1'b1; ld_data = 8'h77;
        tick();
        load = 1'b0;
        shift = 1'b1; rjo = 8'h77; cin = 1'b0;
        tick();
        check("pri_pre_reg", 32'(reg_rji), 32'h3B);
        clear = 1'b1; load = 1'b1; shift = 1'b1; ld_data = 8'h55; rjo = 8'hFF; cin = 1'b1;
        tick();
        clear = 1'b0; load = 1'b0; shift = 1'b0;
        check("pri_reg",  32'(reg_rji),  32'h00);
        check("pri_cnt",  32'(step_cnt), 32'h0);
        check("pri_lsb",  32'(lsb_out),  32'h0);
        check("pri_busy", 32'(busy),     32'h0);
        check("pri_done", 32'(done),     32'h0);

        // ---------------- stall and restart ----------------
        load = 1'b1; ld_data = 8'hF0;
        tick();
        load = 1'b0;
        shift = 1'b1; cin = 1'b0;
        rjo = 8'hF0; tick();
        rjo = 8'h78; tick();
        rjo = 8'h3C; tick();
        check("stall_pre_reg", 32'(reg_rji),  32'h1E);
        check("stall_pre_cnt", 32'(step_cnt), 32'h3);
        ena = 1'b0; rjo = 8'hFF; cin = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("stall_reg%0d", i),  32'(reg_rji),  32'h1E);
            check($sformatf("stall_cnt%0d", i),  32'(step_cnt), 32'h3);
            check($sformatf("stall_busy%0d", i), 32'(busy),     32'h1);
        end
        ena = 1'b1; cin = 1'b0;
        rjo = 8'h1E; tick();
        rjo = 8'h0F; tick();
        shift = 1'b0;
        check("stall_post_reg", 32'(reg_rji),  32'h07);
        check("stall_post_lsb", 32'(lsb_out),  32'h1);
        check("stall_post_cnt", 32'(step_cnt), 32'h5);
        load = 1'b1; ld_data = 8'h3C;
        tick();
        load = 1'b0;
        check("restart_cnt",  32'(step_cnt), 32'h0);
        check("restart_reg",  32'(reg_rji),  32'h3C);
        check("restart_busy", 32'(busy),     32'h1);
        check("restart_lsb",  32'(lsb_out),  32'h0);

        // ---------------- async reset mid-run ----------------
        shift = 1'b1; rjo = 8'h3C; cin = 1'b1;
        tick();
        shift = 1'b0;
        check("arst_pre_reg", 32'(reg_rji), 32'h9E);
        #3 rstb = 1'b0;
        #1;
        check("arst_reg",  32'(reg_rji),  32'h0);
        check("arst_cnt",  32'(step_cnt), 32'h0);
        check("arst_busy", 32'(busy),     32'h0);
        #2 rstb = 1'b1;
        tick();
        check("arst_hold_busy", 32'(busy), 32'h0);

        // ---------------- dut2: sticky, cin fill, done hold ----------------
        load2 = 1'b1; ld_data2 = 8'h00;
        tick();
        load2 = 1'b0;
        check("stk_load", 32'(sticky2), 32'h0);
        shift2 = 1'b1; rjo2 = 8'h01; cin2 = 2'b11;
        tick();
        check("stk_cin_reg", 32'(reg_rji2), 32'hC0);
        check("stk_lsb",     32'(lsb_out2), 32'h1);
        check("stk_set",     32'(sticky2),  STK);
        rjo2 = 8'h00; cin2 = 2'b00;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("stk_hold%0d", i), 32'(sticky2), STK);
        end
        shift2 = 1'b0;
        check("d2_cnt",  32'(step_cnt2), 32'h4);
        check("d2_done", 32'(done2),     32'h1);
        ena = 1'b0;
        tick(); tick();
        check("d2_done_hold", 32'(done2), 32'h1);
        ena = 1'b1;
        tick();
        check("d2_done_clr", 32'(done2),     32'h0);
        check("d2_cnt_sat",  32'(step_cnt2), 32'h4);
        check("stk_idle",    32'(sticky2),   STK);
        load2 = 1'b1;
        tick();
        load2 = 1'b0;
        check("stk_load_clr", 32'(sticky2), 32'h0);
        check("d2_busy",      32'(busy2),   32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
